// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared turn-timer types, widths and BCD helper
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_EXPIRED
    } turn_state_t;

    localparam int SEC_W                = 5;
    localparam int DEFAULT_TURN_SECONDS = 15;

    // Seconds never exceed 31, so three compare/subtract steps of ten cover the range.
    function automatic logic [7:0] sec_to_bcd(input logic [SEC_W-1:0] s);
        logic [SEC_W-1:0] r;
        logic [3:0]       t;
        r = s;
        t = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (r >= SEC_W'(10)) begin
                r = r - SEC_W'(10);
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/turn_timer_if.sv
// rtl/turn_timer_if.sv - control pulses in, countdown status out
interface turn_timer_if;
    import game_pkg::*;

    logic             start;
    logic             halt;
    logic             pause;
    logic             turn_end;
    logic             keep_turn;
    logic [SEC_W-1:0] segundo;
    logic [3:0]       decena;
    logic [3:0]       unidad;
    logic             player;
    logic             timeout;
    logic             tick_1hz;
    logic             running;

    modport master (
        output start, halt, pause, turn_end, keep_turn,
        input  segundo, decena, unidad, player, timeout, tick_1hz, running
    );

    modport slave (
        input  start, halt, pause, turn_end, keep_turn,
        output segundo, decena, unidad, player, timeout, tick_1hz, running
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - 0..CLK_HZ-1 cycle counter flagging the last cycle of each second
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] MAX  = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == MAX) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Raw tick; the owner decides whether a higher-priority event swallows it.
    assign tick_o = en_i && (count_q == MAX);

endmodule

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn countdown with pause, halt, expiry and player hand-over
module turn_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = DEFAULT_TURN_SECONDS
) (
    input  logic       clk50MHz,
    input  logic       rst,
    turn_timer_if.slave bus
);

    localparam logic [SEC_W-1:0] TS_V   = SEC_W'(TURN_SECONDS);
    localparam logic [7:0]       TS_BCD = sec_to_bcd(TS_V);

    turn_state_t      state_q, state_d;
    logic [SEC_W-1:0] seg_q, seg_d;
    logic [3:0]       dec_q, uni_q;
    logic [7:0]       bcd_d;
    logic             player_q, player_d;
    logic             timeout_q, timeout_d;
    logic             tick_q, tick_d;
    logic             running_q;
    logic             presc_en, presc_clr, presc_tick;

    assign presc_en = (state_q == ST_RUN) && !bus.halt;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
        .clk    (clk50MHz),
        .rst    (rst),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .tick_o (presc_tick)
    );

    // Events are strictly prioritised; a turn reload swallows a coincident tick.
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        player_d  = player_q;
        timeout_d = 1'b0;
        tick_d    = 1'b0;
        presc_clr = 1'b0;
        if (bus.halt) begin
            state_d = ST_IDLE;
        end else if (bus.start) begin
            seg_d     = TS_V;
            presc_clr = 1'b1;
            state_d   = bus.pause ? ST_PAUSED : ST_RUN;
        end else if ((state_q != ST_IDLE) && (bus.turn_end || bus.keep_turn)) begin
            seg_d     = TS_V;
            presc_clr = 1'b1;
            if (bus.turn_end) begin
                player_d = ~player_q;
            end
            if (state_q == ST_EXPIRED) begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_EXPIRED) begin
            seg_d     = TS_V;
            presc_clr = 1'b1;
            state_d   = ST_RUN;
        end else if (presc_tick) begin
            tick_d = 1'b1;
            if (seg_q <= SEC_W'(1)) begin
                seg_d     = '0;
                timeout_d = 1'b1;
                player_d  = ~player_q;
                state_d   = ST_EXPIRED;
            end else begin
                seg_d = seg_q - 1'b1;
            end
        end else if ((state_q == ST_RUN) && bus.pause) begin
            state_d = ST_PAUSED;
        end else if ((state_q == ST_PAUSED) && !bus.pause) begin
            state_d = ST_RUN;
        end
        bcd_d = sec_to_bcd(seg_d);
    end

    always_ff @(posedge clk50MHz or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            seg_q     <= TS_V;
            dec_q     <= TS_BCD[7:4];
            uni_q     <= TS_BCD[3:0];
            player_q  <= 1'b0;
            timeout_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            dec_q     <= bcd_d[7:4];
            uni_q     <= bcd_d[3:0];
            player_q  <= player_d;
            timeout_q <= timeout_d;
            tick_q    <= tick_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign bus.segundo  = seg_q;
    assign bus.decena   = dec_q;
    assign bus.unidad   = uni_q;
    assign bus.player   = player_q;
    assign bus.timeout  = timeout_q;
    assign bus.tick_1hz = tick_q;
    assign bus.running  = running_q;

endmodule

// File: tb/tb_turn_timer.sv
// tb/tb_turn_timer.sv - scoreboard bench for turn_timer (3 s and 15 s instances)
module tb_turn_timer;
    import game_pkg::*;

    typedef struct {
        int cyc;
        int seg;
        bit plr;
        bit tmo;
        bit tck;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    turn_timer_if ifa ();
    turn_timer_if ifb ();

    turn_timer #(.CLK_HZ(4), .TURN_SECONDS(3)) dut_a (
        .clk50MHz (clk),
        .rst      (rst),
        .bus      (ifa.slave)
    );

    turn_timer #(.CLK_HZ(4), .TURN_SECONDS(15)) dut_b (
        .clk50MHz (clk),
        .rst      (rst),
        .bus      (ifb.slave)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic cmp_event(input string tag, input exp_t e, input int seg, input int dec,
                             input int uni, input int plr, input int tmo, input int tck);
        check({tag, "_event_cycle"}, cyc, e.cyc);
        check({tag, "_segundo"}, seg, e.seg);
        check({tag, "_decena"}, dec, e.seg / 10);
        check({tag, "_unidad"}, uni, e.seg % 10);
        check({tag, "_player"}, plr, int'(e.plr));
        check({tag, "_timeout"}, tmo, int'(e.tmo));
        check({tag, "_tick"}, tck, int'(e.tck));
    endtask

    // Monitors: every tick or timeout pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (ifa.tick_1hz || ifa.timeout) begin
            if (qa.size() == 0) begin
                check("A_unexpected_event", 1, 0);
            end else begin
                ea = qa.pop_front();
                cmp_event("A", ea, ifa.segundo, ifa.decena, ifa.unidad,
                          ifa.player, ifa.timeout, ifa.tick_1hz);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.tick_1hz || ifb.timeout) begin
            if (qb.size() == 0) begin
                check("B_unexpected_event", 1, 0);
            end else begin
                eb = qb.pop_front();
                cmp_event("B", eb, ifb.segundo, ifb.decena, ifb.unidad,
                          ifb.player, ifb.timeout, ifb.tick_1hz);
            end
        end
    end

    task automatic to_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, p0, h0, e0;
        {ifa.start, ifa.halt, ifa.pause, ifa.turn_end, ifa.keep_turn} = '0;
        {ifb.start, ifb.halt, ifb.pause, ifb.turn_end, ifb.keep_turn} = '0;

        to_cyc(1);
        check("A_rst_segundo", ifa.segundo, 3);
        check("A_rst_decena", ifa.decena, 0);
        check("A_rst_unidad", ifa.unidad, 3);
        check("A_rst_player", ifa.player, 0);
        check("A_rst_timeout", ifa.timeout, 0);
        check("A_rst_tick", ifa.tick_1hz, 0);
        check("A_rst_running", ifa.running, 0);
        check("B_rst_segundo", ifb.segundo, 15);
        check("B_rst_decena", ifb.decena, 1);
        check("B_rst_unidad", ifb.unidad, 5);
        to_cyc(3);
        rst = 1'b1;
        to_cyc(5);
        s = cyc;

        fork
            begin
                ifb.start = 1'b1;
                @(negedge clk);
                ifb.start = 1'b0;
                for (int k = 1; k <= 6; k++) qb.push_back('{s + 1 + 4 * k, 15 - k, 1'b0, 1'b0, 1'b1});
                to_cyc(s + 25);
                ifb.halt = 1'b1;
                @(negedge clk);
                ifb.halt = 1'b0;
                to_cyc(s + 40);
                check("B_halt_running", ifb.running, 0);
                check("B_halt_segundo", ifb.segundo, 9);
            end
            begin
                // Full turn to expiry, then automatic restart for the other player.
                ifa.start = 1'b1;
                @(negedge clk);
                ifa.start = 1'b0;
                qa.push_back('{s + 5, 2, 1'b0, 1'b0, 1'b1});
                qa.push_back('{s + 9, 1, 1'b0, 1'b0, 1'b1});
                qa.push_back('{s + 13, 0, 1'b1, 1'b1, 1'b1});
                to_cyc(s + 13);
                check("A_expired_running", ifa.running, 0);
                to_cyc(s + 14);
                check("A_after_exp_segundo", ifa.segundo, 3);
                check("A_after_exp_running", ifa.running, 1);
                check("A_after_exp_timeout", ifa.timeout, 0);
                check("A_after_exp_player", ifa.player, 1);

                // Pause for 10 cycles mid-second.
                to_cyc(s + 15);
                p0 = cyc + 1;
                ifa.start = 1'b1;
                @(negedge clk);
                ifa.start = 1'b0;
                to_cyc(p0 + 1);
                ifa.pause = 1'b1;
                to_cyc(p0 + 8);
                check("A_paused_segundo", ifa.segundo, 3);
                check("A_paused_running", ifa.running, 0);
                to_cyc(p0 + 11);
                ifa.pause = 1'b0;
                qa.push_back('{p0 + 14, 2, 1'b1, 1'b0, 1'b1});
                qa.push_back('{p0 + 18, 1, 1'b1, 1'b0, 1'b1});

                // turn_end lands on the expiring tick.
                to_cyc(p0 + 21);
                ifa.turn_end = 1'b1;
                @(negedge clk);
                ifa.turn_end = 1'b0;
                check("A_te_segundo", ifa.segundo, 3);
                check("A_te_player", ifa.player, 0);
                check("A_te_timeout", ifa.timeout, 0);
                qa.push_back('{p0 + 26, 2, 1'b0, 1'b0, 1'b1});
                qa.push_back('{p0 + 30, 1, 1'b0, 1'b0, 1'b1});

                // keep_turn at segundo=1 restarts the second from zero.
                to_cyc(p0 + 30);
                ifa.keep_turn = 1'b1;
                @(negedge clk);
                ifa.keep_turn = 1'b0;
                check("A_kt_segundo", ifa.segundo, 3);
                check("A_kt_player", ifa.player, 0);
                qa.push_back('{p0 + 35, 2, 1'b0, 1'b0, 1'b1});

                to_cyc(p0 + 36);
                ifa.turn_end = 1'b1;
                @(negedge clk);
                ifa.turn_end = 1'b0;
                check("A_te2_player", ifa.player, 1);

                // Asynchronous reset mid-second.
                to_cyc(p0 + 38);
                rst = 1'b0;
                #1;
                check("A_async_rst_segundo", ifa.segundo, 3);
                check("A_async_rst_player", ifa.player, 0);
                check("A_async_rst_running", ifa.running, 0);
                to_cyc(p0 + 40);
                rst = 1'b1;
                @(negedge clk);
                check("A_post_rst_segundo", ifa.segundo, 3);
                check("A_post_rst_player", ifa.player, 0);
                check("A_post_rst_timeout", ifa.timeout, 0);
                to_cyc(p0 + 56);
                check("A_idle_segundo", ifa.segundo, 3);
                check("A_idle_running", ifa.running, 0);

                // halt freezes segundo and returns to IDLE.
                h0 = cyc + 1;
                ifa.start = 1'b1;
                @(negedge clk);
                ifa.start = 1'b0;
                qa.push_back('{h0 + 4, 2, 1'b0, 1'b0, 1'b1});
                to_cyc(h0 + 4);
                ifa.halt = 1'b1;
                @(negedge clk);
                ifa.halt = 1'b0;
                check("A_halt_running", ifa.running, 0);
                to_cyc(h0 + 15);
                check("A_halt_segundo", ifa.segundo, 2);
                check("A_halt_player", ifa.player, 0);
            end
        join

        e0 = cyc;
        to_cyc(e0 + 2);
        check("A_queue_empty", qa.size(), 0);
        check("B_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/turn_timer.md
TURN_TIMER -- requirements
Module: turn_timer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CLK_HZ, 50_000_000, input clock cycles per second.
- TURN_SECONDS, 15, seconds per turn; legal range 1..31.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk50MHz, in, 1, sole clock.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, pulse: begin or restart a turn.
- halt, in, 1, pulse: game over, freeze countdown.
- pause, in, 1, level: hold countdown.
- turn_end, in, 1, pulse: unmatched pair, pass turn to the other player.
- keep_turn, in, 1, pulse: matched pair, same player restarts the turn.
- segundo, out, 5, remaining seconds.
- decena, out, 4, tens digit of segundo.
- unidad, out, 4, units digit of segundo.
- player, out, 1, active player (0 = J1, 1 = J2).
- timeout, out, 1, one-cycle pulse when a turn expires.
- tick_1hz, out, 1, one-cycle pulse on each counted second.
- running, out, 1, high in RUN.

Function
REQ-003 The block SHALL register all outputs; no output SHALL be combinational from inputs.
REQ-004 The block SHALL implement the states IDLE, RUN, PAUSED and EXPIRED.
REQ-005 The prescaler SHALL count 0..CLK_HZ-1 only in RUN, and SHALL hold its value in IDLE and PAUSED.
REQ-006 When the prescaler equals CLK_HZ-1 in RUN, the next cycle SHALL set tick_1hz=1, wrap the prescaler to 0, and decrement segundo.
REQ-007 If segundo==1 at a tick, the next cycle SHALL set segundo=0, timeout=1, state=EXPIRED, and toggle player.
REQ-008 EXPIRED SHALL last exactly one cycle, then: segundo=TURN_SECONDS, prescaler=0, state=RUN, timeout=0.
REQ-009 start, in any state, SHALL load segundo=TURN_SECONDS, clear the prescaler, and enter RUN (or PAUSED if pause=1); player SHALL be unchanged.
REQ-010 turn_end, in RUN, PAUSED or EXPIRED, SHALL reload segundo and the prescaler and toggle player; the state SHALL be unchanged except that EXPIRED goes to RUN.
REQ-011 keep_turn SHALL behave as turn_end but SHALL NOT toggle player.
REQ-012 In IDLE, turn_end and keep_turn SHALL be ignored.
REQ-013 With pause=1, RUN SHALL go to PAUSED; with pause=0, PAUSED SHALL go to RUN; all counters SHALL hold while paused.
REQ-014 halt SHALL enter IDLE from any state; segundo and player SHALL hold.
REQ-015 Same-cycle priority SHALL be: halt > start > turn_end > keep_turn > tick > pause transition.
REQ-016 A tick that would expire in the same cycle as turn_end or keep_turn SHALL be discarded: no timeout pulse, and only one toggle (from turn_end).
REQ-017 decena and unidad SHALL be computed from the next value of segundo and updated in the same cycle as segundo, so the three are always coherent.
REQ-018 segundo SHALL never wrap below 0 and never exceed TURN_SECONDS.

Reset
REQ-019 When rst=0, asynchronously: state=IDLE, prescaler=0, segundo=TURN_SECONDS, decena and unidad equal to its digits, player=0, timeout=0, tick_1hz=0, running=0.
REQ-020 A reset asserted mid-turn SHALL discard any pending tick or timeout; the first cycle after release SHALL show the reset values.

Structure
REQ-021 A shared package game_pkg SHALL hold the enum turn_state_t, the constant SEC_W=5, and the default TURN_SECONDS.
REQ-022 The prescaler SHALL be a sub-module tick_prescaler with enable and clear inputs and a tick output.
REQ-023 The BCD split SHALL use a compare/subtract of tens, not a generic divider.

Verification
REQ-024 The bench SHALL use CLK_HZ=4 and TURN_SECONDS=3, and SHALL cover these scenarios:
- Reset, then start, 12 cycles -> segundo 3,2,1,0 with tick every 4 cycles; timeout one cycle at 0; player=1; next cycle segundo=3, RUN.
- pause high for 10 cycles in mid-second -> segundo and prescaler frozen; after release the remaining cycles of that second complete, then tick.
- turn_end in the same cycle as the expiring tick -> no timeout; player toggles once; segundo=3.
- keep_turn at segundo=1 -> segundo=3, player unchanged, prescaler restarts at 0.
- TURN_SECONDS=15 -> after the 5th tick, segundo=10, decena=1, unidad=0; after the 6th tick, segundo=9, decena=0, unidad=9.
- rst low mid-second in RUN, then high -> IDLE, segundo=3, player=0; no timeout or tick afterwards until start.
